// File: rtl/mips_pkg.sv
// Shared multicycle MIPS constants: FSM state codes, opcode/funct values,
// ALU/extender/next-PC codes and the decoded control bundle.
package mips_pkg;

   localparam logic [2:0] S_RST    = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [1:0] NPC_SEQ  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_J    = 2'b10;

   typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_J, K_BAD} kind_e;

   typedef struct packed {
      logic [1:0] extop;
      logic       b_sel;
      logic [2:0] alu_ctr;
      logic       reg_dst;
      logic       mem_to_reg;
   } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode table; classifies the instruction and
// produces the datapath control bundle latched by the FSM in DECODE.
module mc_decode
   import mips_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec,
   output kind_e      kind
);

   always_comb begin
      dec  = '0;
      kind = K_BAD;
      case (op)
         OP_RTYPE: begin
            dec.reg_dst = 1'b1;
            kind        = K_ALU;
            case (funct)
               FN_ADDU: dec.alu_ctr = ALU_ADD;
               FN_SUBU: dec.alu_ctr = ALU_SUB;
               FN_AND:  dec.alu_ctr = ALU_AND;
               FN_OR:   dec.alu_ctr = ALU_OR;
               FN_SLT:  dec.alu_ctr = ALU_SLT;
               default: begin
                  dec  = '0;
                  kind = K_BAD;
               end
            endcase
         end
         OP_ORI: begin
            dec.extop   = EXT_ZERO;
            dec.b_sel   = 1'b1;
            dec.alu_ctr = ALU_OR;
            kind        = K_ALU;
         end
         OP_ADDIU: begin
            dec.extop   = EXT_SIGN;
            dec.b_sel   = 1'b1;
            dec.alu_ctr = ALU_ADD;
            kind        = K_ALU;
         end
         OP_LUI: begin
            dec.extop   = EXT_LUI;
            dec.b_sel   = 1'b1;
            dec.alu_ctr = ALU_ADD;
            kind        = K_ALU;
         end
         OP_LW: begin
            dec.extop      = EXT_SIGN;
            dec.b_sel      = 1'b1;
            dec.alu_ctr    = ALU_ADD;
            dec.mem_to_reg = 1'b1;
            kind           = K_LW;
         end
         OP_SW: begin
            dec.extop   = EXT_SIGN;
            dec.b_sel   = 1'b1;
            dec.alu_ctr = ALU_ADD;
            kind        = K_SW;
         end
         OP_BEQ: begin
            dec.extop   = EXT_SIGN;
            dec.alu_ctr = ALU_SUB;
            kind        = K_BEQ;
         end
         OP_J:    kind = K_J;
         default: kind = K_BAD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait timeout and sticky error.
// Enables/requests are decoded combinationally from the current state.
module mc_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_re,
   output logic       mem_we,
   output logic       pc_we,
   output logic       ir_we,
   output logic       reg_we,
   output logic [1:0] npc_sel,
   output logic [1:0] extop,
   output logic       b_sel,
   output logic [2:0] alu_ctr,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       err
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   dec_t          dec_q, dec_d;
   kind_e         kind_q, kind_d;

   dec_t          dec_w;
   kind_e         kind_w;

   mc_decode u_decode (
      .op    (op),
      .funct (funct),
      .dec   (dec_w),
      .kind  (kind_w)
   );

   logic timeout;
   assign timeout = (int'(cnt_q) >= MEM_TIMEOUT - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      dec_d   = dec_q;
      kind_d  = kind_q;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      npc_sel = NPC_SEQ;
      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            mem_re = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            case (kind_w)
               K_BAD: state_d = S_ERR;
               K_J: begin
                  pc_we   = 1'b1;
                  npc_sel = NPC_J;
                  state_d = S_FETCH;
               end
               default: begin
                  dec_d   = dec_w;
                  kind_d  = kind_w;
                  state_d = S_EXEC;
               end
            endcase
         end
         S_EXEC: begin
            case (kind_q)
               K_BEQ: begin
                  pc_we   = zero;
                  npc_sel = NPC_BR;
                  state_d = S_FETCH;
               end
               K_LW, K_SW: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            mem_re = (kind_q == K_LW);
            mem_we = (kind_q == K_SW);
            if (mem_ready) state_d = (kind_q == K_LW) ? S_WB : S_FETCH;
            else if (timeout) state_d = S_ERR;
            else cnt_d = cnt_q + CW'(1);
         end
         S_WB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
      // Any state change restarts the wait count, so FETCH/MEM always enter at 0.
      if (state_d != state_q) cnt_d = '0;
      if (state_d == S_ERR) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RST;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         dec_q   <= '0;
         kind_q  <= K_ALU;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         dec_q   <= dec_d;
         kind_q  <= kind_d;
      end
   end

   assign extop      = dec_q.extop;
   assign b_sel      = dec_q.b_sel;
   assign alu_ctr    = dec_q.alu_ctr;
   assign reg_dst    = dec_q.reg_dst;
   assign mem_to_reg = dec_q.mem_to_reg;
   assign err        = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: phase-level reference model, per-cycle compare
// and literal pins on instruction length, decode values and handshakes.
module tb_mc_ctrl;

   localparam int TO = 15;
   // model phases
   localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_ERR = 6;
   // instruction classes
   localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_BAD = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'b0, funct = 6'b0;
   logic       zero = 1'b0, mem_ready = 1'b0;
   logic       mem_re, mem_we, pc_we, ir_we, reg_we, b_sel, reg_dst, mem_to_reg, err;
   logic [1:0] npc_sel, extop;
   logic [2:0] alu_ctr;

   mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we), .pc_we(pc_we),
      .ir_we(ir_we), .reg_we(reg_we), .npc_sel(npc_sel), .extop(extop),
      .b_sel(b_sel), .alu_ctr(alu_ctr), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   bit run_chk = 0;

   // model state
   int m_st = P_RST, m_c = 0, m_cls = C_ALU, m_fetch_n = 0, m_len = 0, m_entry = 0, cyc = 0;
   logic       m_err = 0;
   logic [1:0] m_ext = 0;
   logic       m_bs = 0, m_rd = 0, m_m2r = 0;
   logic [2:0] m_alu = 0;

   // stimulus controls
   int flat = 0, mlat = 0;
   bit noise = 0;

   // snapshots
   logic [1:0] s_ext;
   logic       s_bs;
   logic [2:0] s_alu;
   int seen_br, seen_j, memre_cnt, fetchre_cnt, regwe_cnt, m2r_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void classify(input logic [5:0] o, input logic [5:0] f, output int cls,
                                    output logic [1:0] e, output logic b, output logic [2:0] a,
                                    output logic r, output logic m);
      cls = C_BAD; e = 2'b00; b = 0; a = 3'b000; r = 0; m = 0;
      case (o)
         6'b000000: begin
            r = 1; cls = C_ALU;
            case (f)
               6'b100001: a = 3'b000;
               6'b100011: a = 3'b001;
               6'b100100: a = 3'b010;
               6'b100101: a = 3'b011;
               6'b101010: a = 3'b100;
               default: begin cls = C_BAD; r = 0; end
            endcase
         end
         6'b001101: begin cls = C_ALU; e = 2'b00; b = 1; a = 3'b011; end
         6'b001001: begin cls = C_ALU; e = 2'b01; b = 1; a = 3'b000; end
         6'b001111: begin cls = C_ALU; e = 2'b10; b = 1; a = 3'b000; end
         6'b100011: begin cls = C_LW;  e = 2'b01; b = 1; a = 3'b000; m = 1; end
         6'b101011: begin cls = C_SW;  e = 2'b01; b = 1; a = 3'b000; end
         6'b000100: begin cls = C_BEQ; e = 2'b01; b = 0; a = 3'b001; end
         6'b000010: cls = C_J;
         default:   cls = C_BAD;
      endcase
   endfunction

   task automatic model_step();
      int ns, cls;
      logic [1:0] e; logic b, r, m; logic [2:0] a;
      cyc++;
      if (!rst_n) begin
         m_st = P_RST; m_c = 0; m_err = 0;
         m_ext = 0; m_bs = 0; m_alu = 0; m_rd = 0; m_m2r = 0;
      end else begin
         ns = m_st;
         case (m_st)
            P_RST:   ns = P_FETCH;
            P_FETCH: if (mem_ready) ns = P_DEC; else if (m_c == TO - 1) ns = P_ERR; else m_c++;
            P_DEC: begin
               classify(op, funct, cls, e, b, a, r, m);
               if (cls == C_BAD) ns = P_ERR;
               else if (cls == C_J) ns = P_FETCH;
               else begin
                  ns = P_EXEC; m_cls = cls;
                  m_ext = e; m_bs = b; m_alu = a; m_rd = r; m_m2r = m;
               end
            end
            P_EXEC:  ns = (m_cls == C_BEQ) ? P_FETCH : (m_cls == C_LW || m_cls == C_SW) ? P_MEM : P_WB;
            P_MEM:   if (mem_ready) ns = (m_cls == C_LW) ? P_WB : P_FETCH;
                     else if (m_c == TO - 1) ns = P_ERR; else m_c++;
            P_WB:    ns = P_FETCH;
            default: ns = P_ERR;
         endcase
         if (ns == P_ERR) m_err = 1;
         if (ns != m_st) begin
            m_c = 0;
            if (ns == P_FETCH) begin
               m_fetch_n++; m_len = cyc - m_entry; m_entry = cyc;
            end
         end
         m_st = ns;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // memory responder: ready after a programmed latency, optional stray ready elsewhere
   initial forever begin
      @(posedge clk); #2;
      if (m_st == P_FETCH)    mem_ready = (m_c >= flat);
      else if (m_st == P_MEM) mem_ready = (m_c >= mlat);
      else                    mem_ready = noise;
   end

   // per-cycle compare against the model
   initial forever begin
      int cls;
      logic [1:0] e; logic b, r, m; logic [2:0] a;
      logic e_re, e_we, e_pc, e_ir, e_reg;
      logic [1:0] e_npc;
      @(negedge clk);
      if (run_chk) begin
         classify(op, funct, cls, e, b, a, r, m);
         e_re  = (m_st == P_FETCH) || (m_st == P_MEM && m_cls == C_LW);
         e_we  = (m_st == P_MEM && m_cls == C_SW);
         e_ir  = (m_st == P_FETCH) && mem_ready;
         e_pc  = e_ir || (m_st == P_DEC && cls == C_J) || (m_st == P_EXEC && m_cls == C_BEQ && zero);
         e_npc = (m_st == P_DEC) ? 2'b10 : (m_st == P_EXEC) ? 2'b01 : 2'b00;
         e_reg = (m_st == P_WB);
         chk("mem_re", mem_re, e_re);
         chk("mem_we", mem_we, e_we);
         chk("ir_we", ir_we, e_ir);
         chk("pc_we", pc_we, e_pc);
         chk("reg_we", reg_we, e_reg);
         chk("err", err, m_err);
         if (e_pc) chk("npc_sel", npc_sel, e_npc);
         if (m_st == P_RST || m_st == P_EXEC || m_st == P_MEM || m_st == P_WB) begin
            chk("extop", extop, m_ext);
            chk("b_sel", b_sel, m_bs);
            chk("alu_ctr", alu_ctr, m_alu);
            chk("reg_dst", reg_dst, m_rd);
            chk("mem_to_reg", mem_to_reg, m_m2r);
         end
         if (m_st == P_EXEC) begin
            s_ext = extop; s_bs = b_sel; s_alu = alu_ctr;
            if (pc_we && npc_sel == 2'b01) seen_br++;
         end
         if (m_st == P_DEC && pc_we && npc_sel == 2'b10) seen_j++;
         if (m_st == P_MEM && mem_re) memre_cnt++;
         if (m_st == P_FETCH && mem_re) fetchre_cnt++;
         if (reg_we) regwe_cnt++;
         if (reg_we && mem_to_reg) m2r_cnt++;
      end
   end

   task automatic clr_snap();
      seen_br = 0; seen_j = 0; memre_cnt = 0; fetchre_cnt = 0; regwe_cnt = 0; m2r_cnt = 0;
   endtask

   task automatic wait_fetch(input int maxc, input string nm);
      int n0 = m_fetch_n;
      int k = 0;
      while (m_fetch_n == n0 && m_st != P_ERR && k < maxc) begin
         @(posedge clk); #1; k++;
      end
      if (m_fetch_n == n0 && m_st != P_ERR) chk({nm, "_timeout"}, 1, 0);
   endtask

   task automatic run(input logic [5:0] o, input logic [5:0] f, input int fl, input int ml,
                      input logic z, input string nm);
      op = o; funct = f; flat = fl; mlat = ml; zero = z;
      clr_snap();
      wait_fetch(100, nm);
   endtask

   task automatic do_reset(input string nm);
      rst_n = 0;
      @(posedge clk); #1;
      chk({nm, "_rst_err"}, err, 0);
      chk({nm, "_rst_re"}, mem_re, 0);
      chk({nm, "_rst_pc"}, pc_we, 0);
      rst_n = 1; flat = 0; mlat = 0;
      wait_fetch(5, nm);
   endtask

   initial begin
      int k;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      run_chk = 1;
      chk("reset_mem_re", mem_re, 0);
      chk("reset_err", err, 0);
      chk("reset_alu", alu_ctr, 0);
      rst_n = 1;
      wait_fetch(5, "boot");

      run(6'b001001, 6'b0, 0, 0, 0, "addiu");
      chk("addiu_len", m_len, 4);
      chk("addiu_ext", s_ext, 2'b01);
      chk("addiu_bsel", s_bs, 1);
      chk("addiu_regwe", regwe_cnt, 1);

      run(6'b001111, 6'b0, 1, 0, 0, "lui");
      chk("lui_ext", s_ext, 2'b10);
      chk("lui_alu", s_alu, 3'b000);
      chk("lui_bsel", s_bs, 1);
      run(6'b001101, 6'b0, 0, 0, 0, "ori");
      chk("ori_ext", s_ext, 2'b00);
      chk("ori_alu", s_alu, 3'b011);
      chk("ori_bsel", s_bs, 1);

      noise = 1;
      run(6'b000000, 6'b100001, 2, 0, 0, "r_add");
      chk("r_add_len", m_len, 6);
      run(6'b000000, 6'b100011, 0, 0, 1, "r_sub");
      chk("r_sub_alu", s_alu, 3'b001);
      run(6'b000000, 6'b100100, 0, 0, 0, "r_and");
      run(6'b000000, 6'b100101, 0, 0, 0, "r_or");
      run(6'b000000, 6'b101010, 0, 0, 0, "r_slt");
      chk("r_slt_alu", s_alu, 3'b100);
      noise = 0;

      run(6'b000100, 6'b0, 0, 0, 1, "beq_t");
      chk("beq_t_br", seen_br, 1);
      chk("beq_t_len", m_len, 3);
      run(6'b000100, 6'b0, 0, 0, 0, "beq_nt");
      chk("beq_nt_br", seen_br, 0);
      chk("beq_nt_regwe", regwe_cnt, 0);

      run(6'b100011, 6'b0, 0, 3, 0, "lw");
      chk("lw_memre", memre_cnt, 4);
      chk("lw_m2r", m2r_cnt, 1);
      run(6'b101011, 6'b0, 0, 2, 0, "sw");
      chk("sw_regwe", regwe_cnt, 0);
      chk("sw_len", m_len, 6);

      run(6'b000010, 6'b0, 0, 0, 0, "j");
      chk("j_seen", seen_j, 1);
      chk("j_len", m_len, 2);

      run(6'b001001, 6'b0, 100, 0, 0, "fetch_to");
      chk("fetch_to_state", m_st, P_ERR);
      chk("fetch_to_cycles", fetchre_cnt, 15);
      repeat (3) @(posedge clk);
      #1;
      chk("fetch_to_err", err, 1);
      do_reset("rst1");

      run(6'b111111, 6'b0, 0, 0, 0, "bad_op");
      chk("bad_op_state", m_st, P_ERR);
      @(posedge clk); #1;
      chk("bad_op_err", err, 1);
      do_reset("rst2");

      run(6'b000000, 6'b000000, 0, 0, 0, "bad_fn");
      chk("bad_fn_state", m_st, P_ERR);
      do_reset("rst3");

      run(6'b101011, 6'b0, 0, 100, 0, "mem_to");
      chk("mem_to_state", m_st, P_ERR);
      do_reset("rst4");

      // reset while a load waits in MEM
      op = 6'b100011; flat = 0; mlat = 100; clr_snap();
      k = 0;
      while (m_st != P_MEM && k < 20) begin @(posedge clk); #1; k++; end
      chk("abort_in_mem", m_st, P_MEM);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_pre_re", mem_re, 1);
      rst_n = 0;
      @(posedge clk); #1;
      chk("abort_post_re", mem_re, 0);
      rst_n = 1; mlat = 0; op = 6'b001001;
      @(posedge clk); #1;
      chk("abort_fresh_fetch", m_st, P_FETCH);
      chk("abort_fetch_re", mem_re, 1);
      run(6'b001001, 6'b0, 0, 0, 0, "after_abort");
      chk("after_abort_len", m_len, 4);
      chk("after_abort_memre", memre_cnt, 0);

      run_chk = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0t required=finish", $time);
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max consecutive cycles waiting on mem_ready before error.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port op  input  6  opcode field from instruction register.
REQ-005 SHALL have port funct  input  6  function field from instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-008 SHALL have port mem_re / mem_we  output  1 each  memory read / write request.
REQ-009 SHALL have port pc_we, ir_we, reg_we  output  1 each  PC, IR and register-file write enables.
REQ-010 SHALL have port npc_sel  output  2  next PC: 00 pc+4, 01 branch target, 10 jump target.
REQ-011 SHALL have port extop  output  2  extender mode: 00 zero-ext, 01 sign-ext, 10 imm<<16.
REQ-012 SHALL have port b_sel  output  1  ALU B operand: 1 extended immediate, 0 register.
REQ-013 SHALL have port alu_ctr  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-014 SHALL have ports reg_dst, mem_to_reg  output  1 each  rd/rt select and load-data writeback select.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement states RST, FETCH, DECODE, EXEC, MEM, WB, ERR; RST always moves to FETCH on the next cycle.
REQ-017 FETCH SHALL assert mem_re and stay until mem_ready; in the mem_ready cycle it SHALL pulse ir_we and pc_we (npc_sel=00) and move to DECODE.
REQ-018 DECODE SHALL last 1 cycle and register extop, b_sel, alu_ctr, reg_dst and mem_to_reg from op/funct, held constant through EXEC, MEM and WB.
REQ-019 SHALL use this decode table: R-type (op 000000; funct 100001 add, 100011 sub, 100100 and, 100101 or, 101010 slt): b_sel 0, reg_dst 1.
REQ-020 SHALL decode: ori 001101 -> extop 00, b_sel 1, or; addiu 001001 -> 01, 1, add; lui 001111 -> 10, 1, add; lw 100011 / sw 101011 -> 01, 1, add; beq 000100 -> extop 01, b_sel 0, sub.
REQ-021 DECODE with j (000010) SHALL pulse pc_we with npc_sel=10 and return to FETCH.
REQ-022 DECODE with any other op or R-type funct SHALL move to ERR.
REQ-023 EXEC SHALL last 1 cycle: beq -> pc_we=zero, npc_sel=01, then FETCH; lw/sw -> MEM; all others -> WB.
REQ-024 MEM SHALL assert mem_re (lw) or mem_we (sw) until mem_ready; then lw -> WB and sw -> FETCH.
REQ-025 WB SHALL last 1 cycle: reg_we=1, mem_to_reg=1 only for lw, then FETCH.
REQ-026 A wait counter SHALL clear on entry to FETCH/MEM and increment each non-ready cycle; reaching MEM_TIMEOUT SHALL force ERR instead of advancing.
REQ-027 mem_ready in a state not requesting memory SHALL be ignored.
REQ-028 ERR SHALL hold err=1, all enables and requests 0, until reset.
REQ-029 pc_we, ir_we, reg_we, mem_re and mem_we SHALL be combinational from state (plus registered decode, zero, mem_ready); never asserted in RST or ERR.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set state RST, wait counter 0, err 0, extop 00, b_sel 0, alu_ctr 000, reg_dst 0 and mem_to_reg 0, from any state including mid-access.
REQ-031 While in RST all outputs SHALL be 0; a pending memory access aborted by reset SHALL NOT be retried.

Structure
REQ-032 State encoding, opcode/funct constants, alu_ctr and extop codes SHALL live in a shared package (mips_pkg) reused by the datapath.
REQ-033 The decode table SHALL be a separate combinational sub-module, mc_decode; the FSM and wait counter stay in mc_ctrl.

Verification
REQ-034 addiu, mem_ready=1 immediately -> FETCH, DECODE, EXEC, WB (4 cycles); extop=01, b_sel=1, reg_we pulse in WB.
REQ-035 lui, then ori -> extop 10 then 00, b_sel=1 both, alu_ctr 000 then 011.
REQ-036 beq with zero=1, then zero=0 -> pc_we with npc_sel=01 in EXEC only for the zero=1 case; both return to FETCH.
REQ-037 lw with 3 wait cycles in MEM -> mem_re held 4 cycles, WB with mem_to_reg=1; sw -> mem_we held, no WB.
REQ-038 mem_ready held 0 in FETCH for 15 cycles -> ERR, err=1; op 111111 in DECODE -> ERR; rst_n=0 then -> RST, then FETCH.
REQ-039 rst_n=0 during MEM wait -> mem_re drops after the edge, RST for 1 cycle, then a fresh FETCH.
